// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - bridge_timer shared types: FSM states, register offsets, CTRL fields, MODE codes
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PS_LO   = 4;
    localparam int CTRL_PS_HI   = 5;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/tc_prescaler.sv
// rtl/tc_prescaler.sv - 3-bit tick generator, one tick every 2^i_ps cycles while i_run
module tc_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_run,
    input  logic [1:0] i_ps,
    output logic       o_tick
);

    logic [2:0] r_cnt;
    logic [2:0] w_mask;

    assign w_mask = 3'b111 >> (2'd3 - i_ps);
    assign o_tick = i_run && (r_cnt == w_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
        end else if (i_clr) begin
            r_cnt <= 3'd0;
        end else if (i_run) begin
            r_cnt <= o_tick ? 3'd0 : r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/bridge_timer.sv
// rtl/bridge_timer.sv - memory-mapped countdown timer with irq; TC_PRESCALE_EN adds CTRL[5:4] prescaler
module bridge_timer
    import tc_pkg::*;
#(
    parameter int                CNT_W      = 32,
    parameter logic [CNT_W-1:0]  PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e          r_state;
    tc_state_e          w_state_nxt;
    logic               r_en;
    logic               r_im;
    logic [1:0]         r_mode;
    logic               r_irq_flag;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         w_ps;
    logic               w_tick;
    logic               w_ctrl_we;
    logic               w_preset_we;
    logic               w_count_ld;
    logic               w_count_dec;
    logic               w_count_zero;
    logic               w_flag_set;
    logic               w_flag_clr;
    logic               w_en_clr;
    logic [31:0]        w_ctrl_rd;
    logic               w_unused;

    assign w_ctrl_we   = we && (addr[3:2] == REG_CTRL);
    assign w_preset_we = we && (addr[3:2] == REG_PRESET);
    assign w_unused    = ^{addr[31:4], addr[1:0], wdata};

`ifdef TC_PRESCALE_EN
    logic [1:0] r_ps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps <= 2'b00;
        end else if (w_ctrl_we) begin
            r_ps <= wdata[CTRL_PS_HI:CTRL_PS_LO];
        end
    end

    assign w_ps = r_ps;

    tc_prescaler u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  ((r_state == ST_LOAD) || w_ctrl_we),
        .i_run  (r_state == ST_CNT),
        .i_ps   (r_ps),
        .o_tick (w_tick)
    );
`else
    assign w_ps   = 2'b00;
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_count_ld   = 1'b0;
        w_count_dec  = 1'b0;
        w_count_zero = 1'b0;
        w_flag_set   = 1'b0;
        w_flag_clr   = 1'b0;
        w_en_clr     = 1'b0;
        case (r_state)
            ST_IDLE: if (r_en) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_count_ld  = 1'b1;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    // PRESET of 0 or 1 expires on the first step; COUNT never wraps
                    if (r_count > CNT_W'(1)) begin
                        w_count_dec = 1'b1;
                    end else begin
                        w_count_zero = 1'b1;
                        w_flag_set   = 1'b1;
                        w_state_nxt  = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (r_mode == MODE_RELOAD) w_flag_clr = 1'b1;
                else                       w_en_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_preset   <= PRESET_RST;
            r_en       <= 1'b0;
            r_mode     <= MODE_ONESHOT;
            r_im       <= 1'b0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_count_ld)        r_count <= r_preset;
            else if (w_count_dec)  r_count <= r_count - CNT_W'(1);
            else if (w_count_zero) r_count <= '0;
            if (w_preset_we) r_preset <= wdata[CNT_W-1:0];
            // a CTRL write overrides the FSM's one-shot EN clear on the same edge
            if (w_ctrl_we) begin
                r_en   <= wdata[CTRL_EN];
                r_mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                r_im   <= wdata[CTRL_IM];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end
            if (w_flag_set)                    r_irq_flag <= 1'b1;
            else if (w_flag_clr || w_ctrl_we)  r_irq_flag <= 1'b0;
        end
    end

    always_comb begin
        w_ctrl_rd                           = 32'd0;
        w_ctrl_rd[CTRL_EN]                  = r_en;
        w_ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = r_mode;
        w_ctrl_rd[CTRL_IM]                  = r_im;
        w_ctrl_rd[CTRL_PS_HI:CTRL_PS_LO]    = w_ps;
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            REG_CTRL:   rdata = w_ctrl_rd;
            REG_PRESET: rdata = 32'(r_preset);
            REG_COUNT:  rdata = 32'(r_count);
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = r_irq_flag & r_im;

endmodule

// File: tb/tb_bridge_timer.sv
// tb/tb_bridge_timer.sv - self-checking bench for bridge_timer (register vectors plus timing sequences)
module tb_bridge_timer;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total;
    int bad;

    bridge_timer dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

`ifdef TC_PRESCALE_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_003E;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_000E;
`endif

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // caller sits between a negedge and the next posedge; write lands on that posedge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          p;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;

        vecs[0] = '{1'b1, 32'h7f00, 32'hFFFF_FFFE, 32'h7f00, CTRL_ALL,      1'b0};
        vecs[1] = '{1'b1, 32'h7f04, 32'h1234_5678, 32'h7f04, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'h7f08, 32'h0000_FFFF, 32'h7f08, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'h7f0C, 32'h0000_ABCD, 32'h7f0C, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'h7f00, 32'h0,         32'h7f00, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h0,    32'h0,         32'h7f14, 32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, 32'h7f14, 32'h0000_0005, 32'h0004, 32'h0000_0005, 1'b0};
        vecs[7] = '{1'b1, 32'h7f00, 32'h0000_0008, 32'h7f00, 32'h0000_0008, 1'b0};

        step(2);
        reset = 1'b1;

        rd(32'h0, v); chk("rst_ctrl", v, 32'h0);
        rd(32'h4, v); chk("rst_preset", v, 32'h0);
        rd(32'h8, v); chk("rst_count", v, 32'h0);
        rd(32'hC, v); chk("rst_rsvd", v, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].wr_addr, vecs[i].wr_data);
            rd(vecs[i].rd_addr, v);
            chk($sformatf("vec%0d_rd", i), v, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // one-shot, PRESET=3, IM=1
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h9);
        step(1); rd(32'h8, v); chk("os_e1_count", v, 32'd0);
        step(1); rd(32'h8, v); chk("os_e2_count", v, 32'd3);
        step(1); rd(32'h8, v); chk("os_e3_count", v, 32'd2);
        step(1); rd(32'h8, v); chk("os_e4_count", v, 32'd1);
        chk("os_e4_irq", {31'd0, irq}, 32'd0);
        step(1); rd(32'h8, v); chk("os_e5_count", v, 32'd0);
        chk("os_e5_irq", {31'd0, irq}, 32'd1);
        step(1); rd(32'h0, v); chk("os_e6_ctrl", v, 32'h8);
        chk("os_e6_irq", {31'd0, irq}, 32'd1);
        step(3); chk("os_e9_irq_held", {31'd0, irq}, 32'd1);
        wr(32'h0, 32'h8);
        chk("os_ctrlwr_irq_clr", {31'd0, irq}, 32'd0);
        rd(32'h0, v); chk("os_ctrlwr_ctrl", v, 32'h8);
        wr(32'h0, 32'h1);
        step(6);
        rd(32'h0, v); chk("im0_ctrl", v, 32'h0);
        rd(32'h8, v); chk("im0_count", v, 32'd0);
        chk("im0_irq", {31'd0, irq}, 32'd0);

        // auto-reload, PRESET=2: period 5, one-cycle irq
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            exp_cnt = 32'd0;
            exp_irq = 1'b0;
            if (k >= 2) begin
                p = (k - 2) % 5;
                if (p == 0) exp_cnt = 32'd2;
                if (p == 1) exp_cnt = 32'd1;
                if (p == 2) exp_irq = 1'b1;
            end
            rd(32'h8, v);
            chk($sformatf("rl_e%0d_count", k), v, exp_cnt);
            chk($sformatf("rl_e%0d_irq", k), {31'd0, irq}, {31'd0, exp_irq});
        end

        // writes during CNT, EN clear mid-count, restart
        do_reset();
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h1);
        step(3); rd(32'h8, v); chk("cnt_e3", v, 32'd4);
        wr(32'h8, 32'h0000_FFFF);
        rd(32'h8, v); chk("cnt_wr_count_ign", v, 32'd3);
        wr(32'h4, 32'd9);
        rd(32'h8, v); chk("cnt_wr_preset_ign", v, 32'd2);
        rd(32'hC, v); chk("cnt_rsvd", v, 32'd0);
        rd(32'h4, v); chk("cnt_preset_new", v, 32'd9);
        wr(32'h0, 32'h0);
        rd(32'h8, v); chk("cnt_dis_edge", v, 32'd1);
        step(3); rd(32'h8, v); chk("cnt_frozen", v, 32'd1);
        wr(32'h0, 32'h1);
        step(2); rd(32'h8, v); chk("cnt_reload", v, 32'd9);
        step(1); rd(32'h8, v); chk("cnt_reload_dec", v, 32'd8);
        reset = 1'b0;
        #1;
        rd(32'h8, v); chk("async_rst_count", v, 32'd0);
        rd(32'h4, v); chk("async_rst_preset", v, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // PRESET=0 expires on first CNT edge; async reset drops irq
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);
        step(2); chk("p0_e2_irq", {31'd0, irq}, 32'd0);
        step(1); chk("p0_e3_irq", {31'd0, irq}, 32'd1);
        rd(32'h8, v); chk("p0_e3_count", v, 32'd0);
        reset = 1'b0;
        #1;
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        rd(32'h0, v); chk("async_rst_ctrl", v, 32'd0);
        @(negedge clk);
        reset = 1'b1;

`ifdef TC_PRESCALE_EN
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h29);
        rd(32'h0, v); chk("ps_ctrl", v, 32'h29);
        step(5); rd(32'h8, v); chk("ps_e5_count", v, 32'd2);
        step(1); rd(32'h8, v); chk("ps_e6_count", v, 32'd1);
        step(3); chk("ps_e9_irq", {31'd0, irq}, 32'd0);
        step(1); chk("ps_e10_irq", {31'd0, irq}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
